// File: rtl/display_scan_decoder_pkg.sv
// Shared character codes and active-low segment patterns for the 7-segment bus
// encoder, this monitor and its bench.
package display_scan_decoder_pkg;

  localparam logic [4:0] CH_0     = 5'd0;
  localparam logic [4:0] CH_1     = 5'd1;
  localparam logic [4:0] CH_2     = 5'd2;
  localparam logic [4:0] CH_3     = 5'd3;
  localparam logic [4:0] CH_4     = 5'd4;
  localparam logic [4:0] CH_5     = 5'd5;
  localparam logic [4:0] CH_6     = 5'd6;
  localparam logic [4:0] CH_7     = 5'd7;
  localparam logic [4:0] CH_8     = 5'd8;
  localparam logic [4:0] CH_9     = 5'd9;
  localparam logic [4:0] CH_L     = 5'd10;
  localparam logic [4:0] CH_O     = 5'd11;
  localparam logic [4:0] CH_C     = 5'd12;
  localparam logic [4:0] CH_E     = 5'd13;
  localparam logic [4:0] CH_N     = 5'd14;
  localparam logic [4:0] CH_D     = 5'd15;
  localparam logic [4:0] CH_P     = 5'd16;
  localparam logic [4:0] CH_BLANK = 5'd30;
  localparam logic [4:0] CH_UNK   = 5'd31;

  // Patterns are {g,f,e,d,c,b,a}, 0 = segment lit
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_L     = 7'b1000111;
  localparam logic [6:0] SEG_O     = 7'b0100011;
  localparam logic [6:0] SEG_C     = 7'b1000110;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_N     = 7'b0101011;
  localparam logic [6:0] SEG_D     = 7'b0100001;
  localparam logic [6:0] SEG_P     = 7'b0001100;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {AN_IDLE, AN_ONEHOT, AN_ILLEGAL} an_class_e;

  function automatic an_class_e classify_an(input logic [7:0] an);
    logic [7:0] low;
    low = ~an;
    if (an == 8'hFF) return AN_IDLE;
    if ((low & (low - 8'd1)) == 8'h00) return AN_ONEHOT;
    return AN_ILLEGAL;
  endfunction

endpackage

// File: rtl/display_scan_decoder_seg7_char_decode.sv
// Combinational lookup from an active-low cathode pattern to a 5-bit character code.
module seg7_char_decode
  import display_scan_decoder_pkg::*;
(
  input  logic [6:0] seg,
  output logic [4:0] code
);

  always_comb begin
    case (seg)
      SEG_0:     code = CH_0;
      SEG_1:     code = CH_1;
      SEG_2:     code = CH_2;
      SEG_3:     code = CH_3;
      SEG_4:     code = CH_4;
      SEG_5:     code = CH_5;
      SEG_6:     code = CH_6;
      SEG_7:     code = CH_7;
      SEG_8:     code = CH_8;
      SEG_9:     code = CH_9;
      SEG_L:     code = CH_L;
      SEG_O:     code = CH_O;
      SEG_C:     code = CH_C;
      SEG_E:     code = CH_E;
      SEG_N:     code = CH_N;
      SEG_D:     code = CH_D;
      SEG_P:     code = CH_P;
      SEG_BLANK: code = CH_BLANK;
      default:   code = CH_UNK;
    endcase
  end

endmodule

// File: rtl/display_scan_decoder.sv
// Monitors the multiplexed 7-segment bus, captures each settled digit and
// publishes a decoded 8-digit frame once every digit has been seen.
module display_scan_decoder
  import display_scan_decoder_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int CNT_W          = 13
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  AN,
  input  logic        DP,
  input  logic [6:0]  display,
  input  logic        clear_err,
  output logic [39:0] frame_codes,
  output logic [7:0]  frame_dp,
  output logic        frame_valid,
  output logic        anode_err,
  output logic        scan_stall
);

  localparam logic [CNT_W-1:0] SETTLE_MAX = CNT_W'(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] SETTLE_HIT = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_MAX    = CNT_W'(TIMEOUT_CYCLES);

  logic [7:0]       an_reg, an_last_reg;
  logic             dp_reg;
  logic [6:0]       disp_reg;
  logic [CNT_W-1:0] stab_reg, tmo_reg;
  logic [7:0]       seen_reg;
  logic [4:0]       buf_reg [8];
  logic [7:0]       bufdp_reg;
  logic [39:0]      frame_codes_reg;
  logic [7:0]       frame_dp_reg;
  logic             frame_valid_reg, anode_err_reg;

  logic             an_changed, settle_hit, settled, capture, frame_done, err_set;
  an_class_e        an_class;
  logic [2:0]       digit_idx;
  logic [4:0]       code;
  logic [7:0]       seen_next;
  logic [39:0]      merged_codes;
  logic [7:0]       merged_dp;

  seg7_char_decode u_decode (
    .seg  (disp_reg),
    .code (code)
  );

  assign an_class   = classify_an(an_reg);
  assign an_changed = (an_reg != an_last_reg);
  // settle_hit marks the single cycle on which the dwell first becomes settled
  assign settle_hit = !an_changed && (stab_reg == SETTLE_HIT);
  assign settled    = !an_changed && (stab_reg == SETTLE_MAX);
  assign capture    = settle_hit && (an_class == AN_ONEHOT);
  assign err_set    = (settle_hit || settled) && (an_class == AN_ILLEGAL);
  assign seen_next  = seen_reg | (8'b1 << digit_idx);
  assign frame_done = capture && (seen_next == 8'hFF);

  always_comb begin
    digit_idx = 3'd0;
    for (int i = 0; i < 8; i++)
      if (!an_reg[i]) digit_idx = 3'(i);
  end

  // Frame contents include the capture happening on the completing cycle
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_merge
      assign merged_codes[5*gi +: 5] = (capture && digit_idx == 3'(gi)) ? code : buf_reg[gi];
      assign merged_dp[gi] = (capture && digit_idx == 3'(gi)) ? ~dp_reg : bufdp_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_reg          <= 8'hFF;
      an_last_reg     <= 8'hFF;
      dp_reg          <= 1'b1;
      disp_reg        <= 7'h7F;
      stab_reg        <= '0;
      tmo_reg         <= '0;
      seen_reg        <= 8'h00;
      for (int i = 0; i < 8; i++) buf_reg[i] <= CH_UNK;
      bufdp_reg       <= 8'h00;
      frame_codes_reg <= {8{CH_UNK}};
      frame_dp_reg    <= 8'h00;
      frame_valid_reg <= 1'b0;
      anode_err_reg   <= 1'b0;
    end else begin
      an_reg      <= AN;
      an_last_reg <= an_reg;
      dp_reg      <= DP;
      disp_reg    <= display;

      if (an_changed)
        stab_reg <= '0;
      else if (stab_reg != SETTLE_MAX)
        stab_reg <= stab_reg + CNT_W'(1);

      if (capture) begin
        buf_reg[digit_idx]   <= code;
        bufdp_reg[digit_idx] <= ~dp_reg;
      end

      frame_valid_reg <= frame_done;
      if (frame_done) begin
        seen_reg        <= 8'h00;
        frame_codes_reg <= merged_codes;
        frame_dp_reg    <= merged_dp;
      end else if (capture) begin
        seen_reg <= seen_next;
      end

      if (frame_done)
        tmo_reg <= '0;
      else if (tmo_reg != TMO_MAX)
        tmo_reg <= tmo_reg + CNT_W'(1);

      if (err_set)
        anode_err_reg <= 1'b1;
      else if (clear_err)
        anode_err_reg <= 1'b0;
    end
  end

  assign frame_codes = frame_codes_reg;
  assign frame_dp    = frame_dp_reg;
  assign frame_valid = frame_valid_reg;
  assign anode_err   = anode_err_reg;
  assign scan_stall  = (tmo_reg == TMO_MAX);

endmodule

// File: tb/tb_display_scan_decoder.sv
// Randomized bench for display_scan_decoder: a dwell-level model predicts every
// frame, and directed scans cover blanking, errors, glitches, stalls and reset.
module tb_display_scan_decoder;
  import display_scan_decoder_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  AN = 8'hFF;
  logic        DP = 1'b1;
  logic [6:0]  display = 7'h7F;
  logic        clear_err = 1'b0;
  logic [39:0] frame_codes;
  logic [7:0]  frame_dp;
  logic        frame_valid, anode_err, scan_stall;

  display_scan_decoder dut (
    .clk(clk), .rst_n(rst_n), .AN(AN), .DP(DP), .display(display),
    .clear_err(clear_err), .frame_codes(frame_codes), .frame_dp(frame_dp),
    .frame_valid(frame_valid), .anode_err(anode_err), .scan_stall(scan_stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [39:0] codes;
    logic [7:0]  dp;
  } frame_t;

  int          checks = 0, failures = 0;
  int          frames_exp = 0, frames_got = 0;
  frame_t      exp_q[$];
  logic [39:0] m_codes = {8{5'd31}};
  logic [7:0]  m_dp = 8'h00, m_seen = 8'h00, last_an = 8'hFF;
  logic [6:0]  pats [0:16];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference decode: position in the character table, blank, or unknown
  function automatic logic [4:0] ref_decode(input logic [6:0] p);
    for (int i = 0; i < 17; i++) if (p == pats[i]) return 5'(i);
    if (p == 7'h7F) return 5'd30;
    return 5'd31;
  endfunction

  function automatic logic [7:0] sel(input int k);
    return ~(8'h01 << k);
  endfunction

  // One dwell of n cycles; dwells of 8+ cycles on a single digit are captured,
  // dwells of 3 or fewer are not.
  task automatic dwell(input logic [7:0] an, input logic [6:0] disp, input logic dp,
                       input int n, input int glitch_at, input logic [6:0] gdisp);
    frame_t f;
    int k;
    if (an == last_an) begin
      AN = 8'hFF;
      @(negedge clk);
    end
    if (n >= 8 && $countones(~an) == 1) begin
      k = 0;
      for (int i = 0; i < 8; i++) if (!an[i]) k = i;
      m_codes[5*k +: 5] = ref_decode(disp);
      m_dp[k] = ~dp;
      m_seen[k] = 1'b1;
      if (m_seen == 8'hFF) begin
        f.codes = m_codes;
        f.dp = m_dp;
        exp_q.push_back(f);
        frames_exp++;
        m_seen = 8'h00;
      end
    end
    for (int i = 0; i < n; i++) begin
      AN = an;
      DP = dp;
      display = (glitch_at >= 0 && i >= glitch_at) ? gdisp : disp;
      @(negedge clk);
    end
    last_an = an;
  endtask

  task automatic pulse_clear();
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
  endtask

  always @(negedge clk) begin
    frame_t f;
    if (rst_n && frame_valid) begin
      frames_got++;
      if (exp_q.size() == 0) begin
        check("frame_extra", 64'(frame_valid), 64'd0);
      end else begin
        f = exp_q.pop_front();
        check("frame_codes", 64'(frame_codes), 64'(f.codes));
        check("frame_dp", 64'(frame_dp), 64'(f.dp));
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] an_r;
    logic [6:0] d_r;
    int cyc;
    int k;
    pats = '{SEG_0, SEG_1, SEG_2, SEG_3, SEG_4, SEG_5, SEG_6, SEG_7, SEG_8, SEG_9,
             SEG_L, SEG_O, SEG_C, SEG_E, SEG_N, SEG_D, SEG_P};

    repeat (3) @(negedge clk);
    check("rst_codes", 64'(frame_codes), 64'({8{5'd31}}));
    check("rst_dp", 64'(frame_dp), 64'd0);
    check("rst_valid", 64'(frame_valid), 64'd0);
    check("rst_err", 64'(anode_err), 64'd0);
    check("rst_stall", 64'(scan_stall), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Plain digit scan, no decimal points
    for (int i = 0; i < 8; i++) dwell(sel(i), pats[i], 1'b1, 8, -1, 7'h00);
    dwell(8'hFF, 7'h7F, 1'b1, 4, -1, 7'h00);
    check("t1_codes", 64'(frame_codes),
          64'({5'd7, 5'd6, 5'd5, 5'd4, 5'd3, 5'd2, 5'd1, 5'd0}));
    check("t1_dp", 64'(frame_dp), 64'd0);

    // Mixed digits and words, DP lit on digit 5
    dwell(sel(7), SEG_0, 1'b1, 8, -1, 7'h00);
    dwell(sel(6), SEG_1, 1'b1, 8, -1, 7'h00);
    dwell(sel(5), SEG_5, 1'b0, 8, -1, 7'h00);
    dwell(sel(4), SEG_5, 1'b1, 8, -1, 7'h00);
    dwell(sel(3), SEG_L, 1'b1, 8, -1, 7'h00);
    dwell(sel(2), SEG_O, 1'b1, 8, -1, 7'h00);
    dwell(sel(1), SEG_BLANK, 1'b1, 8, -1, 7'h00);
    dwell(sel(0), SEG_BLANK, 1'b1, 8, -1, 7'h00);
    dwell(8'hFF, 7'h7F, 1'b1, 4, -1, 7'h00);
    check("t2_codes", 64'(frame_codes),
          64'({5'd0, 5'd1, 5'd5, 5'd5, 5'd10, 5'd11, 5'd30, 5'd30}));
    check("t2_dp", 64'(frame_dp), 64'h20);

    // Illegal anode pattern, and clear_err losing against a held error
    dwell(8'hFC, SEG_8, 1'b1, 6, -1, 7'h00);
    check("t4_err_set", 64'(anode_err), 64'd1);
    dwell(8'hFF, 7'h7F, 1'b1, 2, -1, 7'h00);
    pulse_clear();
    check("t4_err_clr", 64'(anode_err), 64'd0);
    dwell(8'hFC, SEG_8, 1'b1, 8, -1, 7'h00);
    pulse_clear();
    @(negedge clk);
    check("t4_err_held", 64'(anode_err), 64'd1);
    dwell(8'hFF, 7'h7F, 1'b1, 2, -1, 7'h00);
    pulse_clear();
    check("t4_err_clr2", 64'(anode_err), 64'd0);

    // Post-capture glitch ignored; unknown pattern decodes to 31
    for (int i = 0; i < 8; i++) begin
      if (i == 3) dwell(sel(i), SEG_3, 1'b1, 12, 8, 7'b1110110);
      else if (i == 5) dwell(sel(i), 7'b1010101, 1'b1, 8, -1, 7'h00);
      else dwell(sel(i), pats[i + 8], 1'b1, 8, -1, 7'h00);
    end
    dwell(8'hFF, 7'h7F, 1'b1, 4, -1, 7'h00);
    check("t5_glitch", 64'(frame_codes[19:15]), 64'd3);
    check("t5_unknown", 64'(frame_codes[29:25]), 64'd31);

    // Randomized scans
    for (int n = 0; n < 300; n++) begin
      k = $urandom_range(0, 7);
      d_r = ($urandom_range(0, 99) < 75) ? pats[$urandom_range(0, 16)] :
            ($urandom_range(0, 1) ? 7'h7F : 7'($urandom));
      case ($urandom_range(0, 9))
        0: dwell(8'hFF, d_r, 1'($urandom), $urandom_range(1, 10), -1, 7'h00);
        1: begin
          do an_r = 8'($urandom); while ($countones(~an_r) < 2);
          dwell(an_r, d_r, 1'($urandom), $urandom_range(1, 3), -1, 7'h00);
        end
        default: begin
          if ($urandom_range(0, 9) < 7)
            dwell(sel(k), d_r, 1'($urandom), $urandom_range(8, 12),
                  $urandom_range(0, 3) == 0 ? 7 : -1, 7'($urandom));
          else
            dwell(sel(k), d_r, 1'($urandom), $urandom_range(1, 3), -1, 7'h00);
        end
      endcase
    end
    for (int i = 0; i < 8; i++) dwell(sel(i), pats[i], 1'b1, 8, -1, 7'h00);
    dwell(8'hFF, 7'h7F, 1'b1, 4, -1, 7'h00);
    check("rand_err", 64'(anode_err), 64'd0);

    // Short dwells only: no capture, stall after the timeout, recovery on a frame
    cyc = 0;
    k = 0;
    while (cyc < 4300) begin
      dwell(sel(k), pats[k], 1'b1, 2, -1, 7'h00);
      cyc += 2;
      k = (k + 1) % 8;
      if (cyc == 2000) check("t3_no_stall", 64'(scan_stall), 64'd0);
    end
    check("t3_stall", 64'(scan_stall), 64'd1);
    for (int i = 0; i < 8; i++) dwell(sel(i), pats[15 - i], 1'b0, 9, -1, 7'h00);
    dwell(8'hFF, 7'h7F, 1'b1, 3, -1, 7'h00);
    check("t3_stall_clr", 64'(scan_stall), 64'd0);

    // Reset mid-frame: stale digits must not complete a frame
    for (int i = 5; i < 10; i++) dwell(sel(i % 8), pats[i], 1'b1, 8, -1, 7'h00);
    AN = 8'hFF;
    rst_n = 1'b0;
    @(negedge clk);
    check("t6_rst_codes", 64'(frame_codes), 64'({8{5'd31}}));
    check("t6_rst_dp", 64'(frame_dp), 64'd0);
    check("t6_rst_valid", 64'(frame_valid), 64'd0);
    check("t6_rst_stall", 64'(scan_stall), 64'd0);
    rst_n = 1'b1;
    m_codes = {8{5'd31}};
    m_dp = 8'h00;
    m_seen = 8'h00;
    last_an = 8'hFF;
    @(negedge clk);
    for (int i = 5; i < 13; i++) dwell(sel(i % 8), pats[i], 1'b1, 8, -1, 7'h00);
    dwell(8'hFF, 7'h7F, 1'b1, 4, -1, 7'h00);

    check("pending_frames", 64'(exp_q.size()), 64'd0);
    check("frame_count", 64'(frames_got), 64'(frames_exp));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
